apb_mem_slave: RTL and testbench

- Parametrised APB slave with an internal word-addressed memory, programmable wait states, an error response, and optional byte-lane write strobes.
- Replaces the fixed 8-bit, zero-wait slave.
- Sits behind apb_master, or any APB requester, as a configurable peripheral and register-file model for SoC bring-up and protocol verification.

---
 rtl/apb_mem_slave.sv | 113 +++++++++++
 tb/tb_apb_mem_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB slave with a word-addressed memory, WAIT_STATES stall cycles and an out-of-range error.
// Define APB_MEM_PSTRB_EN to add the pstrb port and byte-lane write strobes.
module apb_mem_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);

   localparam int NB       = DATA_WIDTH / 8;
   localparam int ADDR_LSB = (NB > 1) ? $clog2(NB) : 0;
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
   localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                r_state, w_next;
   logic [3:0]            r_cnt;
   logic [IDX_W-1:0]      r_idx, w_idx;
   logic                  r_write, w_write;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [NB-1:0]         w_strb;
   logic                  w_setup, w_err, w_commit;
   logic                  w_pready_nxt, w_pslverr_nxt;
   logic [DATA_WIDTH-1:0] w_prdata_nxt, w_rdword;
   logic                  w_unused;

   // Byte-offset bits of paddr never select anything.
   assign w_unused = ^paddr;
   assign w_setup  = (r_state == IDLE) && psel && !penable;

`ifdef APB_MEM_PSTRB_EN
   logic [NB-1:0] r_strb;
   always_ff @(posedge pclk or posedge preset)
      if (preset)       r_strb <= '0;
      else if (w_setup) r_strb <= pstrb;
   assign w_strb = r_strb;
`else
   assign w_strb = '1;
`endif

   always_ff @(posedge pclk or posedge preset)
      if (preset) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_setup) w_next = (WAIT_STATES > 0) ? ACCESS : DONE;
         ACCESS:  if (!psel) w_next = IDLE;
                  else if (r_cnt == 4'd1) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // In IDLE the zero-wait path enters DONE straight from setup, so decode the live bus.
   always_comb begin
      w_idx         = (r_state == IDLE) ? paddr[ADDR_WIDTH-1:ADDR_LSB] : r_idx;
      w_write       = (r_state == IDLE) ? pwrite : r_write;
      w_err         = ({1'b0, w_idx} >= DEPTH_L);
      w_rdword      = r_mem[w_idx[MEM_AW-1:0]];
      w_pready_nxt  = (w_next == DONE);
      w_pslverr_nxt = w_pready_nxt && w_err;
      w_prdata_nxt  = prdata;
      if (w_pready_nxt && !w_write) w_prdata_nxt = w_err ? '0 : w_rdword;
      w_commit      = (r_state == DONE) && psel && r_write && !w_err;
   end

   always_ff @(posedge pclk or posedge preset)
      if (preset) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         prdata  <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_setup) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_idx   <= paddr[ADDR_WIDTH-1:ADDR_LSB];
            r_write <= pwrite;
            r_wdata <= pwdata;
         end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt - 4'd1;
         end
         prdata  <= w_prdata_nxt;
         pready  <= w_pready_nxt;
         pslverr <= w_pslverr_nxt;
         if (w_commit)
            for (int b = 0; b < NB; b++)
               if (w_strb[b]) r_mem[r_idx[MEM_AW-1:0]][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: a zero-wait and a 3-wait instance share one APB bus.
module tb_apb_mem_slave;

   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   logic        psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3, pslverr0, pslverr3;
`ifdef APB_MEM_PSTRB_EN
   logic [3:0]  pstrb = 4'hF;
`endif

   int checks = 0;
   int failures = 0;

   always #5 pclk = ~pclk;

   apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
      .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

   apb_mem_slave #(.WAIT_STATES(3)) u_ws3 (
      .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MEM_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

   typedef struct {
      int          d;
      bit          wr;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_waits;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Setup then access; bus values are scrambled during access so only latched ones count.
   // psel stays high afterwards so consecutive calls are back-to-back.
   task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, output logic [31:0] rd, output logic err,
                       output int waits);
      @(posedge pclk); #1;
      psel0 = (d == 0); psel3 = (d == 3); penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = wd;
`ifdef APB_MEM_PSTRB_EN
      pstrb = sb;
`endif
      @(posedge pclk); #1;
      penable = 1'b1; pwrite = ~wr; paddr = a ^ 8'h04; pwdata = ~wd;
      waits = 0;
      forever begin
         @(negedge pclk);
         if ((d == 0) ? pready0 : pready3) break;
         waits++;
         if (waits > 40) begin
            checks++; failures++;
            $display("FAIL timeout: pready never rose, waited %0d cycles", waits);
            break;
         end
      end
      rd  = (d == 0) ? prdata0 : prdata3;
      err = (d == 0) ? pslverr0 : pslverr3;
   endtask

   task automatic idle();
      @(posedge pclk); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          waits;
      int          bad;

      tbl[0]  = '{0, 1, 8'h08, 32'hDEADBEEF, 32'h0,        0, 0};
      tbl[1]  = '{0, 0, 8'h08, 32'h0,        32'hDEADBEEF, 0, 0};
      tbl[2]  = '{0, 1, 8'h40, 32'h00001234, 32'h0,        1, 0};
      tbl[3]  = '{0, 0, 8'h40, 32'h0,        32'h0,        1, 0};
      tbl[4]  = '{0, 0, 8'h00, 32'h0,        32'h0,        0, 0};
      tbl[5]  = '{0, 0, 8'h3C, 32'h0,        32'h0,        0, 0};
      tbl[6]  = '{0, 0, 8'hFC, 32'h0,        32'h0,        1, 0};
      tbl[7]  = '{0, 1, 8'h3C, 32'hA5A5A5A5, 32'h0,        0, 0};
      tbl[8]  = '{0, 0, 8'h3C, 32'h0,        32'hA5A5A5A5, 0, 0};
      tbl[9]  = '{0, 0, 8'h0B, 32'h0,        32'hDEADBEEF, 0, 0};
      tbl[10] = '{3, 1, 8'h04, 32'h5,        32'h0,        0, 3};
      tbl[11] = '{3, 0, 8'h04, 32'h0,        32'h5,        0, 3};
      tbl[12] = '{3, 1, 8'h14, 32'h5,        32'h0,        0, 3};
      tbl[13] = '{3, 1, 8'h18, 32'h6,        32'h0,        0, 3};
      tbl[14] = '{3, 1, 8'h1C, 32'h7,        32'h0,        0, 3};
      tbl[15] = '{3, 0, 8'h14, 32'h0,        32'h5,        0, 3};
      tbl[16] = '{3, 0, 8'h18, 32'h0,        32'h6,        0, 3};
      tbl[17] = '{3, 0, 8'h1C, 32'h0,        32'h7,        0, 3};
      tbl[18] = '{3, 1, 8'h40, 32'h00001234, 32'h0,        1, 3};

      // reset values
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst pready0", {31'b0, pready0}, 32'h0);
      chk("rst pslverr0", {31'b0, pslverr0}, 32'h0);
      chk("rst prdata0", prdata0, 32'h0);
      chk("rst pready3", {31'b0, pready3}, 32'h0);
      chk("rst prdata3", prdata3, 32'h0);
      @(posedge pclk); #1;
      preset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, 4'hF, rd, err, waits);
         chk($sformatf("v%0d pslverr", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
         chk($sformatf("v%0d waits", i), 32'(waits), 32'(tbl[i].exp_waits));
         if (!tbl[i].wr) chk($sformatf("v%0d prdata", i), rd, tbl[i].exp_rd);
      end

      // asynchronous reset in the middle of a stalled read
      xfer(3, 1, 8'h08, 32'h77, 4'hF, rd, err, waits);
      xfer(3, 0, 8'h08, 32'h0, 4'hF, rd, err, waits);
      chk("pre-reset read", rd, 32'h77);
      @(posedge pclk); #1;
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      #1;
      chk("midrst pready3", {31'b0, pready3}, 32'h0);
      chk("midrst pslverr3", {31'b0, pslverr3}, 32'h0);
      chk("midrst prdata3", prdata3, 32'h0);
      chk("midrst prdata0", prdata0, 32'h0);
      @(posedge pclk); #1;
      preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
      xfer(3, 0, 8'h08, 32'h0, 4'hF, rd, err, waits);
      chk("postrst read3", rd, 32'h0);
      chk("postrst waits3", 32'(waits), 32'd3);
      xfer(0, 0, 8'h08, 32'h0, 4'hF, rd, err, waits);
      chk("postrst read0", rd, 32'h0);
      idle();

      // psel dropped during ACCESS: abort, no write, no pready
      @(posedge pclk); #1;
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'h99;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel3 = 1'b0; penable = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge pclk);
         if (pready3) bad++;
      end
      chk("abort pready cycles", 32'(bad), 32'd0);
      xfer(3, 0, 8'h20, 32'h0, 4'hF, rd, err, waits);
      chk("abort access read", rd, 32'h0);
      chk("abort access waits", 32'(waits), 32'd3);
      idle();

      // psel dropped during DONE on the zero-wait slave: write suppressed
      @(posedge pclk); #1;
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h24; pwdata = 32'h55;
      @(posedge pclk); #1;
      psel0 = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      chk("abort done pready", {31'b0, pready0}, 32'h0);
      xfer(0, 0, 8'h24, 32'h0, 4'hF, rd, err, waits);
      chk("abort done read", rd, 32'h0);

`ifdef APB_MEM_PSTRB_EN
      xfer(0, 1, 8'h04, 32'h11223344, 4'hF, rd, err, waits);
      xfer(0, 1, 8'h04, 32'hAABBCCDD, 4'b0101, rd, err, waits);
      xfer(0, 0, 8'h04, 32'h0, 4'hF, rd, err, waits);
      chk("strb merge", rd, 32'h11BB33DD);
      xfer(0, 1, 8'h04, 32'hFFFFFFFF, 4'h0, rd, err, waits);
      chk("strb zero pslverr", {31'b0, err}, 32'h0);
      xfer(0, 0, 8'h04, 32'h0, 4'hF, rd, err, waits);
      chk("strb zero read", rd, 32'h11BB33DD);
`endif
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
